stack_pointer_unit: RTL and testbench
=====================================

Name: stack_pointer_unit

Overview:
- Registered, parametrised stack pointer for the core's descending stack.
- Accepts push, pop and load operations of 1 or 2 words through a valid/ready handshake.
- Produces the registered memory address for each stack access.
- Checks every operation against configurable stack bounds and reports overflow, underflow and bad-load faults; faulting operations do not change SP.
- Sits between the decode/control stage and the data-memory address mux.

Parameters:
ADDR_WIDTH, 32, width of SP and all address values
SP_TOP, 1048575, reset value of SP; highest legal SP (empty stack)
STACK_BOTTOM, 1044480, lowest address the stack may occupy; SP floor is STACK_BOTTOM-1 (full stack)
HALT_ON_FAULT, 1, 1: Op_Ready held low while Fault is set; 0: operations continue, faulting ops still dropped

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  asynchronous reset, active-low
Op_Valid  in  1  operation request
Op_Code  in  3  000 nop, 001 push1, 010 push2, 011 pop1, 100 pop2, 101 load, 110/111 reserved (treated as nop)
Load_Value  in  ADDR_WIDTH  new SP for load
Fault_Clr  in  1  clears sticky Fault and Fault_Code
Op_Ready  out  1  unit can accept an op this cycle
SP  out  ADDR_WIDTH  current stack pointer (registered)
Mem_Addr  out  ADDR_WIDTH  base address for the accepted access (registered)
Mem_Addr_Valid  out  1  Mem_Addr valid this cycle; one-cycle pulse
Used_Words  out  ADDR_WIDTH  SP_TOP - SP (combinational from SP)
Overflow  out  1  one-cycle pulse: push rejected
Underflow  out  1  one-cycle pulse: pop rejected
Fault  out  1  sticky; set by any rejected op
Fault_Code  out  2  00 none, 01 overflow, 10 underflow, 11 bad load; holds the first fault until cleared

Behaviour:
- Reset (Rst=0, asynchronous, any time including mid-operation):
  - SP=SP_TOP, Mem_Addr=0.
  - Mem_Addr_Valid, Overflow, Underflow, Fault = 0; Fault_Code=00.
  - Released synchronously into normal operation on the first edge with Rst=1.
- Accept condition: Op_Valid & Op_Ready at a rising edge.
- Op_Ready = ~(HALT_ON_FAULT & Fault). Combinational; does not depend on Op_Valid.
- Accepted op updates SP at that edge. Mem_Addr/Mem_Addr_Valid are registered at the same edge, so they are visible the cycle after acceptance. Latency is 1 cycle.
- Arithmetic: all compares use ADDR_WIDTH+1 bits; no wrap-around is ever permitted.
  - push1: legal if SP-1 >= STACK_BOTTOM-1. Mem_Addr=SP_old; SP=SP_old-1.
  - push2: legal if SP-2 >= STACK_BOTTOM-1. Mem_Addr=SP_old-1 (lower word of the pair); SP=SP_old-2.
  - pop1: legal if SP+1 <= SP_TOP. SP=SP_old+1; Mem_Addr=SP_old+1.
  - pop2: legal if SP+2 <= SP_TOP. SP=SP_old+2; Mem_Addr=SP_old+1 (lower word of the pair).
  - load: legal if STACK_BOTTOM-1 <= Load_Value <= SP_TOP. SP=Load_Value; Mem_Addr_Valid stays 0.
  - nop/reserved: no state change; no pulses.
- Illegal op:
  - SP unchanged; Mem_Addr_Valid=0.
  - Overflow (push) or Underflow (pop) pulses for 1 cycle; a bad load pulses neither.
  - Fault set. Fault_Code takes the matching code only if it was 00.
- Fault_Clr:
  - Clears Fault and Fault_Code at the next edge.
  - If an op faults in the same cycle, the new fault wins: Fault=1 and Fault_Code=the new code.
  - Fault_Clr and an accepted op in the same cycle are otherwise independent.
- Pulse outputs (Mem_Addr_Valid, Overflow, Underflow) are 0 in any cycle following no accepted op.
- Boundaries:
  - SP=SP_TOP: pop1 and pop2 underflow.
  - SP=SP_TOP-1: pop1 legal, pop2 underflows; partial pops are never performed.
  - SP=STACK_BOTTOM: push1 legal, push2 overflows.
  - SP=STACK_BOTTOM-1: all pushes overflow.

Test Plan:
- Reset then idle: release Rst, hold Op_Valid=0 for 5 cycles -> SP=1048575, Used_Words=0, all flags 0, Op_Ready=1.
- Push/pop sequence: push2, push1, pop1, pop2 back-to-back, Op_Valid held high -> Mem_Addr=1048574, 1048573, 1048573, 1048574 on successive cycles, each with Mem_Addr_Valid=1; SP after each op: 1048573, 1048572, 1048573, 1048575.
- Underflow with halt: pop1 at reset SP -> Underflow pulse, Fault=1, Fault_Code=10, SP unchanged, Op_Ready=0; next push1 is not accepted; assert Fault_Clr -> Op_Ready=1 the following cycle.
- Overflow edge: load 1044480, push1 -> Mem_Addr=1044480, SP=1044479; then push1 -> Overflow pulse, Fault_Code=01, SP stays 1044479.
- Bad load: load Load_Value=1048576 -> no SP change, Fault_Code=11, no Overflow/Underflow pulse. With HALT_ON_FAULT=0, a following push1 is still accepted and Fault_Code stays 11.
- Async reset mid-stream: drop Rst between edges during a push2 burst -> SP=1048575 and Mem_Addr_Valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit
//   Registered stack pointer for a descending stack. It accepts push, pop and
//   load operations of 1 or 2 words through a valid/ready handshake. It
//   produces the registered base address of each access. Every operation is
//   checked against the stack bounds, and an operation that would break them
//   is dropped with a fault report.
//
// Ports
//   Clk            in   clock, rising edge
//   Rst            in   asynchronous reset, active low
//   Op_Valid       in   operation request
//   Op_Code        in   000 nop, 001 push1, 010 push2, 011 pop1, 100 pop2,
//                       101 load, 110/111 nop
//   Load_Value     in   new SP for load
//   Fault_Clr      in   clears sticky Fault / Fault_Code
//   Op_Ready       out  an op can be accepted this cycle
//   SP             out  current stack pointer
//   Mem_Addr       out  base address of the last accepted access
//   Mem_Addr_Valid out  one-cycle pulse, Mem_Addr holds a fresh access
//   Used_Words     out  SP_TOP - SP
//   Overflow       out  one-cycle pulse, push rejected
//   Underflow      out  one-cycle pulse, pop rejected
//   Fault          out  sticky fault flag
//   Fault_Code     out  01 overflow, 10 underflow, 11 bad load (first one held)
module stack_pointer_unit #(
  parameter int unsigned              ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0]    SP_TOP        = 1048575,
  parameter logic [ADDR_WIDTH-1:0]    STACK_BOTTOM  = 1044480,
  parameter bit                       HALT_ON_FAULT = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Op_Valid,
  input  logic [2:0]            Op_Code,
  input  logic [ADDR_WIDTH-1:0] Load_Value,
  input  logic                  Fault_Clr,
  output logic                  Op_Ready,
  output logic [ADDR_WIDTH-1:0] SP,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic                  Mem_Addr_Valid,
  output logic [ADDR_WIDTH-1:0] Used_Words,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  Fault,
  output logic [1:0]            Fault_Code
);

  localparam logic [2:0] OP_PUSH1 = 3'b001;
  localparam logic [2:0] OP_PUSH2 = 3'b010;
  localparam logic [2:0] OP_POP1  = 3'b011;
  localparam logic [2:0] OP_POP2  = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVF   = 2'b01;
  localparam logic [1:0] FC_UNF   = 2'b10;
  localparam logic [1:0] FC_LOAD  = 2'b11;

  // Bounds are compared one bit wider than the address so that nothing
  // can wrap. "x - k >= BOTTOM - 1" is rewritten as "x + 1 >= BOTTOM + k".
  // This keeps every operand non-negative, even when STACK_BOTTOM is 0.
  localparam logic [ADDR_WIDTH:0] TOP_X = {1'b0, SP_TOP};
  localparam logic [ADDR_WIDTH:0] BOT_X = {1'b0, STACK_BOTTOM};
  localparam logic [ADDR_WIDTH:0] X_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] X_TWO = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_TWO = ADDR_WIDTH'(2);

  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_addr_valid_q, mem_addr_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;

  logic                  op_ready;
  logic                  accept;
  logic [ADDR_WIDTH:0]   sp_x;
  logic [ADDR_WIDTH:0]   lv_x;
  logic                  push1_ok, push2_ok, pop1_ok, pop2_ok, load_ok;
  logic                  new_fault;
  logic [1:0]            new_code;

  always_comb begin
    op_ready = ~(HALT_ON_FAULT & fault_q);
    accept   = Op_Valid & op_ready;

    sp_x     = {1'b0, sp_q};
    lv_x     = {1'b0, Load_Value};
    push1_ok = (sp_x + X_ONE) >= (BOT_X + X_ONE);
    push2_ok = (sp_x + X_ONE) >= (BOT_X + X_TWO);
    pop1_ok  = (sp_x + X_ONE) <= TOP_X;
    pop2_ok  = (sp_x + X_TWO) <= TOP_X;
    load_ok  = ((lv_x + X_ONE) >= BOT_X) && (lv_x <= TOP_X);

    sp_d             = sp_q;
    mem_addr_d       = mem_addr_q;
    mem_addr_valid_d = 1'b0;
    overflow_d       = 1'b0;
    underflow_d      = 1'b0;
    new_fault        = 1'b0;
    new_code         = FC_NONE;

    if (accept) begin
      case (Op_Code)
        OP_PUSH1: begin
          if (push1_ok) begin
            sp_d             = sp_q - A_ONE;
            mem_addr_d       = sp_q;
            mem_addr_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
            new_fault  = 1'b1;
            new_code   = FC_OVF;
          end
        end
        OP_PUSH2: begin
          // The base address is the lower word of the pair.
          if (push2_ok) begin
            sp_d             = sp_q - A_TWO;
            mem_addr_d       = sp_q - A_ONE;
            mem_addr_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
            new_fault  = 1'b1;
            new_code   = FC_OVF;
          end
        end
        OP_POP1: begin
          if (pop1_ok) begin
            sp_d             = sp_q + A_ONE;
            mem_addr_d       = sp_q + A_ONE;
            mem_addr_valid_d = 1'b1;
          end else begin
            underflow_d = 1'b1;
            new_fault   = 1'b1;
            new_code    = FC_UNF;
          end
        end
        OP_POP2: begin
          if (pop2_ok) begin
            sp_d             = sp_q + A_TWO;
            mem_addr_d       = sp_q + A_ONE;
            mem_addr_valid_d = 1'b1;
          end else begin
            underflow_d = 1'b1;
            new_fault   = 1'b1;
            new_code    = FC_UNF;
          end
        end
        OP_LOAD: begin
          // A bad load faults, but it does not pulse Overflow or Underflow.
          if (load_ok) begin
            sp_d = Load_Value;
          end else begin
            new_fault = 1'b1;
            new_code  = FC_LOAD;
          end
        end
        default: ;
      endcase
    end

    // The clear applies first. A fault in the same cycle then wins, and it
    // can overwrite the code because the clear has emptied it.
    fault_d      = fault_q & ~Fault_Clr;
    fault_code_d = Fault_Clr ? FC_NONE : fault_code_q;
    if (new_fault) begin
      fault_d = 1'b1;
      if (fault_code_d == FC_NONE) begin
        fault_code_d = new_code;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sp_q             <= SP_TOP;
      mem_addr_q       <= '0;
      mem_addr_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      fault_q          <= 1'b0;
      fault_code_q     <= FC_NONE;
    end else begin
      sp_q             <= sp_d;
      mem_addr_q       <= mem_addr_d;
      mem_addr_valid_q <= mem_addr_valid_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
      fault_q          <= fault_d;
      fault_code_q     <= fault_code_d;
    end
  end

  assign Op_Ready       = op_ready;
  assign SP             = sp_q;
  assign Mem_Addr       = mem_addr_q;
  assign Mem_Addr_Valid = mem_addr_valid_q;
  assign Used_Words     = SP_TOP - sp_q;
  assign Overflow       = overflow_q;
  assign Underflow      = underflow_q;
  assign Fault          = fault_q;
  assign Fault_Code     = fault_code_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb_stack_pointer_unit
//   Drives two copies of stack_pointer_unit with identical stimulus: one with
//   HALT_ON_FAULT=1 and one with HALT_ON_FAULT=0. For each cycle, a reference
//   model written in terms of used words and stack capacity predicts the
//   outputs after the next edge. The prediction is queued, and one monitor per
//   instance pops it and compares it after that edge.
module tb_stack_pointer_unit;

  localparam longint TOP = 1048575;
  localparam longint BOT = 1044480;

  typedef struct {
    longint   sp;
    longint   mem_addr;
    longint   uw;
    bit       mav;
    bit       ovf;
    bit       unf;
    bit       fault;
    bit [1:0] code;
  } obs_t;

  logic        Clk, Rst, Op_Valid, Fault_Clr;
  logic [2:0]  Op_Code;
  logic [31:0] Load_Value;

  logic        rdy1, mav1, ovf1, unf1, flt1;
  logic [31:0] sp1, ma1, uw1;
  logic [1:0]  fc1;
  logic        rdy0, mav0, ovf0, unf0, flt0;
  logic [31:0] sp0, ma0, uw0;
  logic [1:0]  fc0;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   run      = 0;
  obs_t q1[$];
  obs_t q0[$];
  obs_t m1, m0;

  stack_pointer_unit #(.ADDR_WIDTH(32), .SP_TOP(32'd1048575), .STACK_BOTTOM(32'd1044480),
                       .HALT_ON_FAULT(1'b1)) dut_halt (
    .Clk(Clk), .Rst(Rst), .Op_Valid(Op_Valid), .Op_Code(Op_Code),
    .Load_Value(Load_Value), .Fault_Clr(Fault_Clr), .Op_Ready(rdy1), .SP(sp1),
    .Mem_Addr(ma1), .Mem_Addr_Valid(mav1), .Used_Words(uw1), .Overflow(ovf1),
    .Underflow(unf1), .Fault(flt1), .Fault_Code(fc1)
  );

  stack_pointer_unit #(.ADDR_WIDTH(32), .SP_TOP(32'd1048575), .STACK_BOTTOM(32'd1044480),
                       .HALT_ON_FAULT(1'b0)) dut_run (
    .Clk(Clk), .Rst(Rst), .Op_Valid(Op_Valid), .Op_Code(Op_Code),
    .Load_Value(Load_Value), .Fault_Clr(Fault_Clr), .Op_Ready(rdy0), .SP(sp0),
    .Mem_Addr(ma0), .Mem_Addr_Valid(mav0), .Used_Words(uw0), .Overflow(ovf0),
    .Underflow(unf0), .Fault(flt0), .Fault_Code(fc0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t reset_state();
    obs_t r;
    r.sp = TOP; r.mem_addr = 0; r.uw = 0;
    r.mav = 0; r.ovf = 0; r.unf = 0; r.fault = 0; r.code = 0;
    return r;
  endfunction

  // Reference model. A push of k words fits if used+k stays within the capacity.
  // A pop of k words needs at least k used words.
  function automatic obs_t step(obs_t s, bit halt, bit v, bit [2:0] op, longint lv, bit clr);
    obs_t     n;
    longint   used, cap, k;
    bit       bad;
    bit [1:0] code;
    n = s; n.mav = 0; n.ovf = 0; n.unf = 0;
    bad = 0; code = 0;
    if (clr) begin n.fault = 0; n.code = 0; end
    used = TOP - s.sp;
    cap  = TOP - BOT + 1;
    if (v && !(halt && s.fault)) begin
      case (op)
        3'd1, 3'd2: begin
          k = longint'(op);
          if (used + k <= cap) begin
            n.sp = s.sp - k; n.mem_addr = n.sp + 1; n.mav = 1;
          end else begin
            n.ovf = 1; bad = 1; code = 2'b01;
          end
        end
        3'd3, 3'd4: begin
          k = longint'(op) - 2;
          if (used >= k) begin
            n.sp = s.sp + k; n.mem_addr = s.sp + 1; n.mav = 1;
          end else begin
            n.unf = 1; bad = 1; code = 2'b10;
          end
        end
        3'd5: begin
          if (lv >= BOT - 1 && lv <= TOP) n.sp = lv;
          else begin bad = 1; code = 2'b11; end
        end
        default: ;
      endcase
    end
    if (bad) begin
      n.fault = 1;
      if (s.code == 0 || clr) n.code = code;
    end
    n.uw = TOP - n.sp;
    return n;
  endfunction

  task automatic check_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".sp"},         a.sp,       e.sp);
    chk({tag, ".used_words"}, a.uw,       e.uw);
    chk({tag, ".mem_valid"},  a.mav,      e.mav);
    if (e.mav) chk({tag, ".mem_addr"}, a.mem_addr, e.mem_addr);
    chk({tag, ".overflow"},   a.ovf,      e.ovf);
    chk({tag, ".underflow"},  a.unf,      e.unf);
    chk({tag, ".fault"},      a.fault,    e.fault);
    chk({tag, ".fault_code"}, a.code,     e.code);
  endtask

  // Apply one cycle's inputs, which are already positioned at a falling
  // edge. Queue the predicted post-edge outputs.
  task automatic apply(input bit v, input bit [2:0] op, input logic [31:0] lv, input bit clr);
    Op_Valid = v; Op_Code = op; Load_Value = lv; Fault_Clr = clr;
    chk("halt.op_ready", rdy1, m1.fault ? 0 : 1);
    chk("run.op_ready",  rdy0, 1);
    m1 = step(m1, 1'b1, v, op, longint'(lv), clr);
    m0 = step(m0, 1'b0, v, op, longint'(lv), clr);
    q1.push_back(m1);
    q0.push_back(m0);
    $display("op v=%0d code=%0d lv=%0d clr=%0d -> exp halt sp=%0d fc=%0d | run sp=%0d fc=%0d",
             v, op, lv, clr, m1.sp, m1.code, m0.sp, m0.code);
  endtask

  task automatic cycle(input bit v, input bit [2:0] op, input logic [31:0] lv, input bit clr);
    @(negedge Clk);
    apply(v, op, lv, clr);
  endtask

  function automatic logic [31:0] pick_load();
    logic [31:0] r;
    case ($urandom_range(0, 6))
      0: r = 32'(BOT - 2);
      1: r = 32'(BOT - 1);
      2: r = 32'(BOT);
      3: r = 32'(TOP);
      4: r = 32'(TOP + 1);
      5: r = 32'(BOT) + $urandom_range(0, 4095);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic rand_cycle();
    bit       v, clr;
    bit [2:0] op;
    int       r;
    v   = ($urandom_range(0, 9) < 8);
    clr = ($urandom_range(0, 11) == 0);
    r   = $urandom_range(0, 19);
    if (r <= 5)       op = 3'd1;
    else if (r <= 8)  op = 3'd2;
    else if (r <= 13) op = 3'd3;
    else if (r <= 16) op = 3'd4;
    else if (r == 17) op = 3'd5;
    else if (r == 18) op = 3'd0;
    else              op = 3'($urandom_range(6, 7));
    cycle(v, op, pick_load(), clr);
  endtask

  // Monitors: one prediction is consumed per clock edge while running.
  always @(posedge Clk) begin
    obs_t e, a;
    #1;
    if (run) begin
      if (q1.size() == 0) begin
        chk("halt.queue_empty", 1, 0);
      end else begin
        e = q1.pop_front();
        a.sp = sp1; a.mem_addr = ma1; a.uw = uw1; a.mav = mav1;
        a.ovf = ovf1; a.unf = unf1; a.fault = flt1; a.code = fc1;
        check_obs("halt", a, e);
      end
    end
  end

  always @(posedge Clk) begin
    obs_t e, a;
    #1;
    if (run) begin
      if (q0.size() == 0) begin
        chk("run.queue_empty", 1, 0);
      end else begin
        e = q0.pop_front();
        a.sp = sp0; a.mem_addr = ma0; a.uw = uw0; a.mav = mav0;
        a.ovf = ovf0; a.unf = unf0; a.fault = flt0; a.code = fc0;
        check_obs("run", a, e);
      end
    end
  end

  initial begin
    Rst = 1'b1; Op_Valid = 0; Op_Code = 0; Load_Value = 0; Fault_Clr = 0;
    m1 = reset_state(); m0 = reset_state();
    #2 Rst = 1'b0;
    #1;
    chk("reset.sp",       sp1,  TOP);
    chk("reset.mem_addr", ma1,  0);
    chk("reset.fault",    flt1, 0);
    chk("reset.code",     fc1,  0);
    repeat (2) @(posedge Clk);

    // Release the reset, then stay idle for 5 cycles.
    @(negedge Clk);
    Rst = 1'b1; run = 1;
    apply(0, 3'd0, 0, 0);
    repeat (4) cycle(0, 3'd0, 0, 0);

    // Back-to-back push/pop sequence.
    cycle(1, 3'd2, 0, 0);
    cycle(1, 3'd1, 0, 0);
    cycle(1, 3'd3, 0, 0);
    cycle(1, 3'd4, 0, 0);

    // Underflow at an empty stack. The next push is blocked while halted.
    cycle(1, 3'd3, 0, 0);
    cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 0, 1);
    cycle(0, 3'd0, 0, 0);

    // Overflow at the floor.
    cycle(1, 3'd5, 32'(BOT), 0);
    cycle(1, 3'd1, 0, 0);
    cycle(1, 3'd1, 0, 0);
    cycle(1, 3'd2, 0, 1);
    cycle(0, 3'd0, 0, 1);

    // Bad load above the top, followed by a push.
    cycle(1, 3'd5, 32'(TOP + 1), 0);
    cycle(1, 3'd1, 0, 0);
    cycle(0, 3'd0, 0, 1);

    // Boundary pops just below the top.
    cycle(1, 3'd5, 32'(TOP - 1), 0);
    cycle(1, 3'd4, 0, 0);
    cycle(1, 3'd3, 0, 1);

    repeat (500) rand_cycle();

    // Asynchronous reset in the middle of a push2 burst.
    cycle(0, 3'd0, 0, 1);
    cycle(1, 3'd5, 32'(TOP), 0);
    repeat (3) cycle(1, 3'd2, 0, 0);
    @(posedge Clk);
    #3;
    run = 0;
    Rst = 1'b0;
    #1;
    chk("async_rst.halt.sp",        sp1,  TOP);
    chk("async_rst.halt.mem_valid", mav1, 0);
    chk("async_rst.run.sp",         sp0,  TOP);
    chk("async_rst.run.mem_valid",  mav0, 0);
    chk("async_rst.halt.used",      uw1,  0);
    q1.delete(); q0.delete();
    m1 = reset_state(); m0 = reset_state();
    @(negedge Clk);
    Rst = 1'b1; run = 1;
    apply(1, 3'd2, 0, 0);
    repeat (40) rand_cycle();

    @(posedge Clk);
    #3;
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
